// File: rtl/fm_phaseinc_gen.sv
// rtl/fm_phaseinc_gen.sv - audio sample to DDS phase increment with linear ramp between samples
// Optional FM_PHASEINC_SAT_EN clamps the target increment instead of wrapping it.
module fm_phaseinc_gen #(
  parameter int NBITS_AUDIO = 16,
  parameter int NBITS_GAIN  = 16,
  parameter int GAIN_SHIFT  = 16,
  parameter int INTERP_LOG2 = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enableclk,
  input  logic [31:0]            carrier_inc,
  input  logic [NBITS_GAIN-1:0]  dev_gain,
  input  logic [NBITS_AUDIO-1:0] sample,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic [31:0]            phaseinc,
  output logic                   busy,
  output logic                   overrun
);

  localparam int PW = NBITS_AUDIO + NBITS_GAIN + 1;
  localparam logic [8:0] RAMP_LAST = 9'((1 << INTERP_LOG2) - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MULT, S_CALC, S_RAMP} state_t;

  state_t                        state_q, state_d;
  logic [31:0]                   phaseinc_q, phaseinc_d;
  logic                          overrun_q, overrun_d;
  logic [8:0]                    cnt_q, cnt_d;
  logic signed [NBITS_AUDIO-1:0] sample_q, sample_d;
  logic [NBITS_GAIN-1:0]         gain_q, gain_d;
  logic [31:0]                   carrier_q, carrier_d;
  logic signed [PW-1:0]          product_q, product_d;
  logic [31:0]                   target_q, target_d;
  logic [31:0]                   step_q, step_d;

  logic signed [PW-1:0] mul_a, mul_b;
  logic signed [31:0]   scaled;
  logic [31:0]          target_calc;
  logic [31:0]          diff;

  assign mul_a  = PW'(sample_q);
  assign mul_b  = PW'({1'b0, gain_q});
  assign scaled = 32'(64'(product_q) >>> GAIN_SHIFT);

`ifdef FM_PHASEINC_SAT_EN
  logic signed [33:0] sum34;
  assign sum34 = $signed({2'b00, carrier_q}) + 34'(scaled);
  assign target_calc = sum34[33] ? 32'h0000_0000 :
                       sum34[32] ? 32'hFFFF_FFFF : sum34[31:0];
`else
  assign target_calc = carrier_q + $unsigned(scaled);
`endif

  // Signed difference picks the shortest way round the 2^32 circle.
  assign diff = target_calc - phaseinc_q;

  always_comb begin
    state_d    = state_q;
    phaseinc_d = phaseinc_q;
    overrun_d  = overrun_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    gain_d     = gain_q;
    carrier_d  = carrier_q;
    product_d  = product_q;
    target_d   = target_q;
    step_d     = step_q;

    if (sample_valid && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_INIT: begin
        phaseinc_d = carrier_inc;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        if (sample_valid) begin
          sample_d  = sample;
          gain_d    = dev_gain;
          carrier_d = carrier_inc;
          state_d   = S_MULT;
        end
      end
      S_MULT: begin
        product_d = mul_a * mul_b;
        state_d   = S_CALC;
      end
      S_CALC: begin
        target_d = target_calc;
        step_d   = 32'($signed(diff) >>> INTERP_LOG2);
        cnt_d    = 9'd0;
        state_d  = S_RAMP;
      end
      S_RAMP: begin
        if (enableclk) begin
          cnt_d = cnt_q + 9'd1;
          // Final tick lands on the exact target, absorbing step truncation.
          if (cnt_q < RAMP_LAST) begin
            phaseinc_d = phaseinc_q + step_q;
          end else begin
            phaseinc_d = target_q;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_INIT;
      phaseinc_q <= '0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
      sample_q   <= '0;
      gain_q     <= '0;
      carrier_q  <= '0;
      product_q  <= '0;
      target_q   <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      phaseinc_q <= phaseinc_d;
      overrun_q  <= overrun_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      gain_q     <= gain_d;
      carrier_q  <= carrier_d;
      product_q  <= product_d;
      target_q   <= target_d;
      step_q     <= step_d;
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign phaseinc     = phaseinc_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fm_phaseinc_gen.sv
// tb/tb_fm_phaseinc_gen.sv - self-checking bench for fm_phaseinc_gen
module tb_fm_phaseinc_gen;

  localparam int     RAMP  = 16;
  localparam longint TWO31 = 64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;

  logic        clock = 1'b0;
  logic        reset;
  logic        enableclk;
  logic [31:0] carrier_inc;
  logic [15:0] dev_gain;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] phaseinc;
  logic        busy;
  logic        overrun;

  always #5 clock = ~clock;

  fm_phaseinc_gen #(
    .NBITS_AUDIO(16), .NBITS_GAIN(16), .GAIN_SHIFT(16), .INTERP_LOG2(4)
  ) dut (
    .clock(clock), .reset(reset), .enableclk(enableclk),
    .carrier_inc(carrier_inc), .dev_gain(dev_gain), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .phaseinc(phaseinc), .busy(busy), .overrun(overrun)
  );

  int          vecs = 0;
  int          miscompares = 0;
  logic [31:0] cur;

  typedef struct {
    logic [31:0] carrier;
    logic [15:0] gain;
    logic [15:0] smp;
    logic [31:0] final_exp;
    int          period;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] model_target(logic [31:0] car, logic [15:0] g, logic [15:0] s);
    longint prod, scaled, sum;
    prod   = longint'($signed(s)) * longint'({1'b0, g});
    scaled = prod >>> 16;
    sum    = longint'(car) + scaled;
`ifdef FM_PHASEINC_SAT_EN
    if (sum < 0) return 32'h0000_0000;
    if (sum >= TWO32) return 32'hFFFF_FFFF;
    return sum[31:0];
`else
    return sum[31:0];
`endif
  endfunction

  function automatic logic [31:0] model_step(logic [31:0] tgt, logic [31:0] from);
    longint d, st;
    d = longint'(tgt) - longint'(from);
    if (d >= TWO31) d = d - TWO32;
    else if (d < -TWO31) d = d + TWO32;
    if (d >= 0) st = d / RAMP;
    else        st = -((-d + RAMP - 1) / RAMP);
    return st[31:0];
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(logic [31:0] car);
    reset = 1'b1;
    carrier_inc = car;
    cyc();
    check("rst_phaseinc", phaseinc, 32'h0);
    check("rst_ready", {31'b0, sample_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b0;
    enableclk = 1'b0;
    cyc();
    check("init_phaseinc", phaseinc, car);
    check("init_ready", {31'b0, sample_ready}, 32'd1);
    check("init_busy", {31'b0, busy}, 32'd0);
    cur = car;
  endtask

  task automatic run_sample(logic [31:0] car, logic [15:0] g, logic [15:0] s, logic [31:0] final_exp,
                            int period, int pulse_at, int abort_at);
    logic [31:0] st, exp;
    int n = 0;
    while (!sample_ready && n < 100) begin
      cyc();
      n++;
    end
    check("ready_before_accept", {31'b0, sample_ready}, 32'd1);
    carrier_inc = car; dev_gain = g; sample = s;
    sample_valid = 1'b1;
    enableclk = 1'b1;
    cyc();
    sample_valid = 1'b0;
    check("accept_busy", {31'b0, busy}, 32'd1);
    check("accept_hold", phaseinc, cur);
    st  = model_step(final_exp, cur);
    exp = cur;
    carrier_inc = $urandom; dev_gain = 16'($urandom); sample = 16'($urandom);
    cyc();
    check("mult_hold", phaseinc, cur);
    cyc();
    check("calc_hold", phaseinc, cur);
    for (int k = 1; k <= RAMP; k++) begin
      enableclk = 1'b0;
      for (int i = 1; i < period; i++) cyc();
      if (period > 1) check("no_tick_hold", phaseinc, exp);
      if (k == abort_at) begin
        enableclk = 1'b1;
        do_reset(32'h1000_0000);
        return;
      end
      enableclk = 1'b1;
      if (k == pulse_at) begin
        sample_valid = 1'b1;
        sample = 16'($urandom);
      end
      cyc();
      sample_valid = 1'b0;
      exp = (k == RAMP) ? final_exp : exp + st;
      check($sformatf("tick%0d", k), phaseinc, exp);
      if (k == pulse_at) check("overrun_set", {31'b0, overrun}, 32'd1);
      if (k < RAMP) check("ramp_ready", {31'b0, sample_ready}, 32'd0);
    end
    enableclk = 1'b0;
    check("done_ready", {31'b0, sample_ready}, 32'd1);
    check("done_busy", {31'b0, busy}, 32'd0);
    cur = final_exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] c;
    logic [15:0] g, s;
    tbl[0] = '{32'h1000_0000, 16'h0100, 16'h4000, 32'h1000_0040, 4};
    tbl[1] = '{32'h1000_0000, 16'h0100, 16'h0000, 32'h1000_0000, 4};
    tbl[2] = '{32'h1000_0000, 16'h0100, 16'hC000, 32'h0FFF_FFC0, 4};
    tbl[3] = '{32'h1000_0000, 16'h0100, 16'h0000, 32'h1000_0000, 4};
    tbl[4] = '{32'h1000_0000, 16'h0100, 16'h4600, 32'h1000_0046, 4};
`ifdef FM_PHASEINC_SAT_EN
    tbl[5] = '{32'hFFFF_FFF0, 16'h0100, 16'h4000, 32'hFFFF_FFFF, 2};
`else
    tbl[5] = '{32'hFFFF_FFF0, 16'h0100, 16'h4000, 32'h0000_0030, 2};
`endif

    reset = 1'b1; enableclk = 1'b0; sample_valid = 1'b0;
    carrier_inc = 32'h1000_0000; dev_gain = '0; sample = '0;
    cyc();
    do_reset(32'h1000_0000);

    for (int i = 0; i < 6; i++)
      run_sample(tbl[i].carrier, tbl[i].gain, tbl[i].smp, tbl[i].final_exp, tbl[i].period, 0, 0);

    run_sample(32'h1000_0000, 16'h0100, 16'h4000,
               model_target(32'h1000_0000, 16'h0100, 16'h4000), 3, 5, 0);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);
    run_sample(32'h2000_0000, 16'h0200, 16'h1234,
               model_target(32'h2000_0000, 16'h0200, 16'h1234), 2, 0, 7);
    check("abort_overrun_clear", {31'b0, overrun}, 32'd0);

    for (int r = 0; r < 20; r++) begin
      c = $urandom; g = 16'($urandom); s = 16'($urandom);
      run_sample(c, g, s, model_target(c, g, s), int'($urandom_range(1, 3)), 0, 0);
    end

    reset = 1'b1; carrier_inc = 32'h0ABC_0000;
    cyc();
    reset = 1'b0; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
    check("init_overrun", {31'b0, overrun}, 32'd1);
    check("init_reload", phaseinc, 32'h0ABC_0000);
    check("init_drop_ready", {31'b0, sample_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
